multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Multicycle control unit for the TessiaV1 datapath. It replaces the single-cycle
//  decode path with an FSM that sequences fetch, decode, execute, memory and
//  writeback over several cycles. It adds a NZCV flags register with full condition
//  evaluation, a memory-ready handshake and a multi-cycle multiplier handshake.
//  Sits between the instruction register and the shared ALU/memory datapath.
// PARAMETERS
//  ALU_CTRL_W   4        ALUControl width (>=4; upper bits driven 0)
//  MEM_WAIT_EN  1        1: honour mem_ready; 0: memory treated as single-cycle (mem_ready ignored, taken as 1)
//  FLAGS_RST    4'b0000  NZCV value loaded on reset
// PORTS
//  clk         in   1           clock, rising edge
//  reset       in   1           asynchronous, active-high
//  Op          in   2           instr[27:26]; Funct in 6 instr[25:20]; Rd in 4 instr[15:12]; Cond in 4 instr[31:28]
//  ALUFlags    in   4           NZCV from ALU, current cycle
//  mem_ready   in   1           memory completed the access requested by mem_req
//  mul_done    in   1           multiplier result valid (1-cycle pulse)
//  PCWrite, IRWrite, RegW, MemW  out 1  write strobes
//  AdrSrc, ALUSrcA  out 1; ResultSrc, ALUSrcB, ImmSrc, RegSrc  out 2  datapath muxes
//  ALUControl  out  ALU_CTRL_W  ALU op
//  mem_req     out  1           memory access request (fetch/load/store)
//  mul_start   out  1           1-cycle pulse launching multiply
//  illegal_op  out  1           1-cycle pulse in DECODE when Op==2'b11
//  flags_q     out  4           stored NZCV
// BEHAVIOUR
//  Reset: state=FETCH, flags_q=FLAGS_RST. All strobes, mem_req, mul_start and illegal_op are 0 while reset is high.
//    Reset mid-operation abandons any pending access or multiply.
//  Moore outputs decoded from state; ImmSrc/RegSrc combinational from Op:
//    DP 00/00, LDR 01/00, STR 01/10, B 10/01.
//  CondEx is combinational from Cond and flags_q (EQ..LE, 1110=AL, 1111=never).
//    It gates RegW, MemW, branch PCWrite and flag updates.
//  FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
//    IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready; otherwise hold.
//  DECODE (1 cycle) transitions:
//    Op=01 -> MEMADR
//    Op=00 with Funct[5] -> EXECI; Op=00 without Funct[5] -> EXECR
//    Op=10 -> BRANCH
//    Op=11 -> FETCH with illegal_op=1 and no writes
//  MEMADR: ALUSrcB=01, ADD if Funct[3] else SUB.
//    !CondEx -> FETCH; Funct[0] -> MEMRD; else -> MEMWR.
//  MEMRD: mem_req=1, AdrSrc=1; on mem_ready -> MEMWB.
//  MEMWB: RegW=1, ResultSrc=01; -> FETCH.
//  MEMWR: mem_req=1, MemW=1, AdrSrc=1; held until mem_ready -> FETCH.
//  EXECR/EXECI: ALUSrcB=00/01. ALU decode on Funct[4:1]:
//    0100 ADD=0, 0010 SUB=1, 0000 MUL=2, 1100 ORR=3, 1101 MOV=6, 1010 CMP=1; others ADD.
//    MUL: mul_start=1 -> MULWAIT.
//    CMP (NoWrite): update flags -> FETCH.
//    Otherwise: update flags -> ALUWB.
//  MULWAIT: hold until mul_done; flag update on that cycle -> ALUWB.
//  Flag update when Funct[0]&CondEx: NZ always; CV only for ADD/SUB/CMP. MUL/ORR/MOV keep C,V.
//  ALUWB: RegW=CondEx, ResultSrc=00. If Rd==15 & CondEx, PCWrite=1. -> FETCH.
//  BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx; -> FETCH.
//  mem_ready outside FETCH/MEMRD/MEMWR and mul_done outside MULWAIT are ignored.
//  Latency with mem_ready tied 1: DP=4 cycles, CMP=3, LDR=5, STR=4, B=3, MUL=5+wait.
// TESTING
//  1. reset high mid-MEMWR -> next cycle MemW=0, mem_req=0; release -> FETCH, flags_q=FLAGS_RST
//  2. ADDS (Op=00,Funct=101001), ALUFlags=0110, Cond=1110 -> FETCH,DECODE,EXECI,ALUWB;
//     RegW=1 in ALUWB; flags_q=0110
//  3. EQ branch with flags_q Z=0 -> BRANCH, PCWrite=0; repeat with Z=1 -> PCWrite=1 in BRANCH
//  4. LDR with mem_ready low 3 cycles in MEMRD -> mem_req held 3 cycles, MEMWB on 4th, RegW=1 once
//  5. MULS -> mul_start 1 cycle; mul_done after 6 cycles -> flags NZ updated, C,V unchanged, ALUWB RegW=1
//  6. CMP Funct=010101 -> flags updated, no ALUWB, RegW never 1; Op=11 -> illegal_op pulse, back to FETCH

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the TessiaV1 datapath: sequences fetch/decode/execute/memory/writeback,
// holds the NZCV flags register and handles the memory-ready and multiplier handshakes.
module multicycle_controller #(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter logic [3:0]  FLAGS_RST   = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic [3:0]            Cond,
    input  logic [3:0]            ALUFlags,
    input  logic                  mem_ready,
    input  logic                  mul_done,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic                  RegW,
    output logic                  MemW,
    output logic                  AdrSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  mem_req,
    output logic                  mul_start,
    output logic                  illegal_op,
    output logic [3:0]            flags_q
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_ORR = 4'd3;
    localparam logic [3:0] ALU_MOV = 4'd6;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_MULWAIT, S_ALUWB, S_BRANCH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_d;
    logic       mem_rdy;
    logic       cond_ex;
    logic [3:0] alu_op;
    logic [3:0] alu_sel;
    logic       cv_upd;
    logic       is_mul;
    logic       is_cmp;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    // Condition evaluation against the stored NZCV
    always_comb begin
        cond_ex = 1'b0;
        unique case (Cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing function decode; unknown encodings fall back to ADD
    always_comb begin
        alu_op = ALU_ADD;
        cv_upd = 1'b1;
        is_mul = 1'b0;
        is_cmp = 1'b0;
        unique case (Funct[4:1])
            4'b0100: alu_op = ALU_ADD;
            4'b0010: alu_op = ALU_SUB;
            4'b0000: begin alu_op = ALU_MUL; cv_upd = 1'b0; is_mul = 1'b1; end
            4'b1100: begin alu_op = ALU_ORR; cv_upd = 1'b0; end
            4'b1101: begin alu_op = ALU_MOV; cv_upd = 1'b0; end
            4'b1010: begin alu_op = ALU_SUB; is_cmp = 1'b1; end
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        unique case (Op)
            2'b01:   begin ImmSrc = 2'b01; RegSrc = Funct[0] ? 2'b00 : 2'b10; end
            2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
            default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= FLAGS_RST;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        alu_sel    = ALU_ADD;
        mem_req    = 1'b0;
        mul_start  = 1'b0;
        illegal_op = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_rdy;
                PCWrite   = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                unique case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin illegal_op = 1'b1; state_d = S_FETCH; end
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                alu_sel = Funct[3] ? ALU_ADD : ALU_SUB;
                if (!cond_ex)     state_d = S_FETCH;
                else if (Funct[0]) state_d = S_MEMRD;
                else              state_d = S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegW      = cond_ex;
                ResultSrc = 2'b01;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                MemW    = cond_ex;
                AdrSrc  = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_sel = alu_op;
                if (is_mul) begin
                    mul_start = 1'b1;
                    state_d   = S_MULWAIT;
                end else begin
                    if (Funct[0] && cond_ex)
                        flags_d = {ALUFlags[3:2], cv_upd ? ALUFlags[1:0] : flags_q[1:0]};
                    state_d = is_cmp ? S_FETCH : S_ALUWB;
                end
            end
            S_MULWAIT: begin
                alu_sel = alu_op;
                if (mul_done) begin
                    // Multiply only produces N and Z; carry/overflow are preserved
                    if (Funct[0] && cond_ex) flags_d = {ALUFlags[3:2], flags_q[1:0]};
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                RegW    = cond_ex;
                PCWrite = cond_ex && (Rd == 4'd15);
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Nothing may strobe while reset is held, even though state reads as FETCH
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegW       = 1'b0;
            MemW       = 1'b0;
            mem_req    = 1'b0;
            mul_start  = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign ALUControl = ALU_CTRL_W'(alu_sel);

endmodule
